// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the loader byte stream and the instruction fetch bus.
//   rx_data  : loader byte              (master -> slave)
//   rx_valid : rx_data valid            (master -> slave)
//   rx_ready : loader can take a byte   (slave -> master)
//   im_abus  : fetch address            (master -> slave)
//   im_dbus  : fetched instruction byte (slave -> master)
// The loader (imem_loader) is the slave; the byte source / core side is the master.
interface imem_loader_if #(
   parameter int AW = 5
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] im_abus;
   logic [7:0]    im_dbus;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      output im_abus,
      input  im_dbus
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      input  im_abus,
      output im_dbus
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loadable DEPTH x 8 instruction memory with a framed byte-stream
// loader. Frame = length N, N program bytes (written to 0..N-1), then an
// 8-bit additive checksum. The core is held in reset until a frame verifies.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : imem_loader_if.slave (rx_data/rx_valid/rx_ready, im_abus/im_dbus)
//   reload    : restart loading, honoured only in DONE or ERROR
//   cpu_reset : active-high reset to the core (low only in DONE)
//   load_done : a verified program is resident
//   load_err  : the last frame was rejected
module imem_loader #(
   parameter int DEPTH   = 32,
   parameter int MAX_LEN = 32
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus,
   input  logic         reload,
   output logic         cpu_reset,
   output logic         load_done,
   output logic         load_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DATA  = 3'd1,
      S_CHECK = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [7:0]    sum_q, sum_d;
   logic          rx_ready_q, rx_ready_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          load_done_q, load_done_d;
   logic          load_err_q, load_err_d;
   logic          xfer_s;
   logic          mem_we_s;
   logic [7:0]    mem [DEPTH];

   // 8-bit modular checksum accumulation
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   // Next-state, pointer/checksum update and registered Moore output decode
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      ptr_d    = ptr_q;
      sum_d    = sum_q;
      mem_we_s = 1'b0;
      xfer_s   = bus.rx_valid & rx_ready_q;
      case (state_q)
         S_IDLE: begin
            if (xfer_s) begin
               if ((bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > MAX_LEN_W)) begin
                  state_d = S_ERROR;
               end else begin
                  len_d   = bus.rx_data[LW-1:0];
                  ptr_d   = '0;
                  sum_d   = 8'd0;
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (xfer_s) begin
               mem_we_s = 1'b1;
               sum_d    = csum_add(sum_q, bus.rx_data);
               ptr_d    = ptr_q + AW'(1);
               // the byte landing on N-1 ends the payload
               if (({1'b0, ptr_q} + LW'(1)) == len_q) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_CHECK: begin
            if (xfer_s) begin
               if (bus.rx_data == sum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERROR;
               end
            end else begin
               state_d = S_CHECK;
            end
         end
         S_DONE, S_ERROR: begin
            // rx_ready is low here, so reload never competes with a byte
            if (reload) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // outputs decoded from the next state so the flops match the state register
      rx_ready_d  = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_CHECK);
      cpu_reset_d = (state_d != S_DONE);
      load_done_d = (state_d == S_DONE);
      load_err_d  = (state_d == S_ERROR);
   end

   // Loader FSM state, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         ptr_q       <= '0;
         sum_q       <= 8'd0;
         rx_ready_q  <= 1'b1;
         cpu_reset_q <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         ptr_q       <= ptr_d;
         sum_q       <= sum_d;
         rx_ready_q  <= rx_ready_d;
         cpu_reset_q <= cpu_reset_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   // Program array write port; contents deliberately survive reset and reload
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem[ptr_q] <= bus.rx_data;
      end
   end

   assign bus.im_dbus  = mem[bus.im_abus];
   assign bus.rx_ready = rx_ready_q;
   assign cpu_reset    = cpu_reset_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
endmodule
